freq_divider_prog: RTL and testbench
====================================

// Module: freq_divider_prog
// PURPOSE
//  Programmable, fully synchronous clock-enable divider: divides clk by a runtime-loadable
//  integer N and produces a one-cycle tick plus a divided waveform (square or pulse).
//  Supersedes the fixed 18-stage ripple T-flip-flop chain: single clock domain, no derived clocks.
//  Feeds display multiplexing, debounce and timer logic as a clock enable.
// PARAMETERS
//  WIDTH        18  counter/divisor width in bits; max divisor 2^WIDTH-1
//  DEFAULT_DIV  2   divisor after reset; must satisfy 2 <= DEFAULT_DIV <= 2^WIDTH-1
// PORTS
//  clk       in   1      system clock, single clock domain
//  rst_n     in   1      asynchronous active-low reset
//  en        in   1      count enable; counter frozen when 0
//  mode      in   1      0 = square wave on div_out, 1 = pulse (div_out mirrors tick)
//  div_in    in   WIDTH  new divisor value
//  div_load  in   1      one-cycle request to load div_in
//  tick      out  1      one-cycle pulse, once per N enabled cycles
//  div_out   out  1      divided waveform, registered
//  count     out  WIDTH  current counter value, 0..N-1
//  pending   out  1      a loaded divisor is waiting for the period boundary
//  load_ack  out  1      one-cycle pulse: new divisor now in effect
//  load_err  out  1      one-cycle pulse: div_load rejected (div_in < 2)
// BEHAVIOUR
//  - Reset (async assert, sync release): cnt=0, N=DEFAULT_DIV, tick=0, div_out=0, pending=0,
//    load_ack=0, load_err=0.
//  - All outputs are registered.
//  - en=1: cnt <= (cnt==N-1) ? 0 : cnt+1.
//    tick <= (cnt==N-1); first tick is on the Nth enabled edge after reset.
//  - en=0: cnt holds; tick <= 0; div_out holds.
//  - Square mode: div_out <= (next cnt < ceil(N/2)), so it is high for ceil(N/2) of each
//    N cycles. Odd N gives the longer half high.
//  - Pulse mode: div_out <= tick.
//  - A mode change takes effect on the next edge; the counter is not disturbed.
//  - Divisor update:
//    - div_load with div_in>=2: capture into pend_div and set pending=1.
//    - Applied at the period boundary (edge where en=1 and cnt==N-1): N <= pend_div,
//      cnt <= 0, pending <= 0, load_ack=1.
//    - Periods are never truncated.
//    - If en=0 when pending, apply on the next edge: cnt <= 0, load_ack=1.
//  - div_load with div_in in {0,1}: load_err=1 for one cycle; N and pending are unchanged.
//  - A second div_load while pending: the newer value overwrites pend_div; one load_ack only.
//  - div_load on the same edge as the boundary:
//    - the old pend_div (if any) is applied at this edge;
//    - the new value becomes pending for the next boundary.
//  - N = 2^WIDTH-1: cnt reaches all-ones-1 and wraps to 0; no overflow is possible.
//  - Reset mid-period or mid-pending: all state returns to reset values and the pending load is lost.
// STRUCTURE
//  - Package freq_div_pkg:
//    - MODE_SQUARE / MODE_PULSE constants
//    - MIN_DIV = 2
//    - helper function half_period(N) = (N+1)>>1
//  - Sub-module freq_div_core: counter, compare and output registers. Inputs: N, en, mode.
//    Outputs: wrap, tick, div_out, count.
//  - Top level: divisor/pending registers, load_ack and load_err logic.
// TESTING
//  1. Reset, en=1, default N=2, square: tick every 2nd cycle; div_out toggles each cycle.
//     Reset mid-run restores cnt=0, div_out=0.
//  2. Load div_in=5, square mode, en=1: in each 5-cycle period div_out is high 3 cycles and
//     low 2; tick every 5 cycles.
//  3. Mid-period load of 3 while N=8 at cnt=2:
//     - pending=1 until cnt hits 7;
//     - load_ack on the wrap edge;
//     - following ticks are 3 cycles apart;
//     - no period shorter than 8 before the switch.
//  4. div_load with div_in=0 and then 1: load_err pulses; N, pending and tick spacing are unchanged.
//  5. Toggle en=0 for 4 cycles at cnt=3 (N=6): count holds 3, tick stays low; the next tick
//     comes 3 enabled cycles after en returns.
//     Load while en=0: takes effect on the next edge with cnt=0.
//  6. WIDTH=4 with N=15, pulse mode: tick and div_out are identical, 15 cycles apart.
//     Back-to-back loads of 4 then 9: only 9 is applied, with a single load_ack.

Source files
------------

// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the programmable clock-enable divider.
package freq_div_pkg;

    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;
    localparam int   MIN_DIV     = 2;

    // Number of high cycles per period in square mode; odd divisors get the longer half high.
    function automatic logic [32:0] half_period(input logic [32:0] n);
        return (n + 33'd1) >> 1;
    endfunction

endpackage

// File: rtl/freq_divider_prog_core.sv
// Counter, terminal-count compare and registered tick/div_out for a given divisor.
module freq_div_core
    import freq_div_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             clear,
    input  logic [WIDTH-1:0] div,
    output logic             wrap,
    output logic             tick,
    output logic             div_out,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             div_out_q, div_out_d;
    logic             at_last;

    assign at_last = (cnt_q == div - WIDTH'(1));
    assign wrap    = en && at_last;

    always_comb begin
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        div_out_d = div_out_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_last ? '0 : cnt_q + WIDTH'(1);
        end
        // The waveform follows the counter only while enabled; it freezes otherwise.
        if (en) begin
            tick_d = at_last;
            if (mode == MODE_PULSE) begin
                div_out_d = at_last;
            end else begin
                div_out_d = (33'(cnt_d) < half_period(33'(div)));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            div_out_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            div_out_q <= div_out_d;
        end
    end

    assign tick    = tick_q;
    assign div_out = div_out_q;
    assign count   = cnt_q;

endmodule

// File: rtl/freq_divider_prog.sv
// Programmable clock-enable divider: divisor/pending-load bookkeeping around the counter core.
module freq_divider_prog
    import freq_div_pkg::*;
#(
    parameter int WIDTH       = 18,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             tick,
    output logic             div_out,
    output logic [WIDTH-1:0] count,
    output logic             pending,
    output logic             load_ack,
    output logic             load_err
);

    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pending_q, pending_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             wrap;
    logic             load_ok;
    logic             apply;

    assign load_ok = div_load && (div_in >= WIDTH'(MIN_DIV));
    // A waiting divisor lands on the period boundary, or immediately while the counter is frozen.
    assign apply   = pending_q && (wrap || !en);

    always_comb begin
        div_d      = div_q;
        pend_div_d = pend_div_q;
        pending_d  = pending_q;
        ack_d      = apply;
        err_d      = div_load && !load_ok;
        if (apply) begin
            div_d     = pend_div_q;
            pending_d = 1'b0;
        end
        // A load on the apply edge queues behind the value being applied.
        if (load_ok) begin
            pend_div_d = div_in;
            pending_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= WIDTH'(DEFAULT_DIV);
            pend_div_q <= '0;
            pending_q  <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pending_q  <= pending_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    freq_div_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .mode   (mode),
        .clear  (apply),
        .div    (div_q),
        .wrap   (wrap),
        .tick   (tick),
        .div_out(div_out),
        .count  (count)
    );

    assign pending  = pending_q;
    assign load_ack = ack_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_freq_divider_prog.sv
// Directed bench: expected pulse edges and state snapshots are queued, a monitor matches them.
module tb_freq_divider_prog;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         mode;
    logic [W-1:0] div_in;
    logic         div_load;
    logic         tick;
    logic         div_out;
    logic [W-1:0] count;
    logic         pending;
    logic         load_ack;
    logic         load_err;

    freq_divider_prog #(
        .WIDTH      (W),
        .DEFAULT_DIV(2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .div_in  (div_in),
        .div_load(div_load),
        .tick    (tick),
        .div_out (div_out),
        .count   (count),
        .pending (pending),
        .load_ack(load_ack),
        .load_err(load_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int e;
        int cnt;
        int dv;
        int pend;
    } snap_t;

    int    pq[3][$];
    snap_t sq[$];
    string pname[3] = '{"tick", "load_ack", "load_err"};
    int    checks = 0;
    int    errors = 0;

    task automatic expect_pulse(input int k, input int e);
        pq[k].push_back(e);
    endtask

    task automatic snap(input int e, input int c, input int d, input int p);
        snap_t s;
        s.e = e; s.cnt = c; s.dv = d; s.pend = p;
        sq.push_back(s);
    endtask

    // Monitor: one look per clock, 1 time unit after the edge
    always begin
        logic [2:0] p;
        int         e;
        snap_t      s;
        @(posedge clk);
        #1;
        e = cyc;
        p = {load_err, load_ack, tick};
        for (int k = 0; k < 3; k++) begin
            while (pq[k].size() > 0 && pq[k][0] < e) begin
                checks++; errors++;
                $display("FAIL %s missing: expected pulse at edge %0d, got none", pname[k], pq[k][0]);
                void'(pq[k].pop_front());
            end
            if (p[k]) begin
                checks++;
                if (pq[k].size() > 0 && pq[k][0] == e) begin
                    void'(pq[k].pop_front());
                    $display("edge %0d: %s pulse ok", e, pname[k]);
                end else begin
                    errors++;
                    $display("FAIL %s unexpected: got pulse at edge %0d, expected none (next %0d)",
                             pname[k], e, (pq[k].size() > 0) ? pq[k][0] : -1);
                end
            end else if (pq[k].size() > 0 && pq[k][0] == e) begin
                checks++; errors++;
                $display("FAIL %s missing: got 0 at edge %0d, expected 1", pname[k], e);
                void'(pq[k].pop_front());
            end
        end
        while (sq.size() > 0 && sq[0].e <= e) begin
            s = sq.pop_front();
            if (s.e == e) begin
                checks++;
                if (int'(count) != s.cnt) begin
                    errors++;
                    $display("FAIL count @edge %0d: got %0d, expected %0d", e, count, s.cnt);
                end
                checks++;
                if (int'(pending) != s.pend) begin
                    errors++;
                    $display("FAIL pending @edge %0d: got %0d, expected %0d", e, pending, s.pend);
                end
                if (s.dv >= 0) begin
                    checks++;
                    if (int'(div_out) != s.dv) begin
                        errors++;
                        $display("FAIL div_out @edge %0d: got %0d, expected %0d", e, div_out, s.dv);
                    end
                end
                $display("edge %0d: snapshot count=%0d pending=%0d div_out=%0d", e, count, pending, div_out);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; div_load = 1'b0; div_in = '0;
        for (int k = 0; k < 3; k++) pq[k].delete();
        sq.delete();
        snap(cyc + 1, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load(input int v);
        div_load = 1'b1;
        div_in   = v[W-1:0];
        @(negedge clk);
        div_load = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; div_load = 1'b0; div_in = '0;
        @(negedge clk);

        // 1: default N=2 square, then reset mid-period
        do_reset();
        b = cyc; en = 1'b1;
        for (int i = 1; i <= 3; i++) expect_pulse(0, b + 2 * i);
        snap(b + 1, 1, 0, 0); snap(b + 2, 0, 1, 0); snap(b + 3, 1, 0, 0);
        wait_until(b + 7);
        do_reset();

        // 2: N=5 square, 3 high / 2 low
        b = cyc; en = 1'b1;
        expect_pulse(1, b + 2);
        for (int i = 0; i < 4; i++) expect_pulse(0, b + 2 + 5 * i);
        snap(b + 1, 1, 0, 1); snap(b + 2, 0, 1, 0); snap(b + 3, 1, 1, 0); snap(b + 4, 2, 1, 0);
        snap(b + 5, 3, 0, 0); snap(b + 6, 4, 0, 0); snap(b + 7, 0, 1, 0);
        load(5);
        wait_until(b + 17);
        do_reset();

        // 3: N=8, load 3 at cnt=2, switch only at the wrap
        b = cyc; en = 1'b1;
        expect_pulse(1, b + 2); expect_pulse(1, b + 10);
        expect_pulse(0, b + 2); expect_pulse(0, b + 10); expect_pulse(0, b + 13);
        expect_pulse(0, b + 16); expect_pulse(0, b + 19);
        snap(b + 5, 3, 1, 1); snap(b + 9, 7, 0, 1); snap(b + 10, 0, 1, 0);
        snap(b + 11, 1, 1, 0); snap(b + 12, 2, 0, 0);
        load(8);
        wait_until(b + 4);
        load(3);
        wait_until(b + 19);
        load(7);
        do_reset();

        // 4: reset dropped the pending 7; invalid loads flag errors only
        b = cyc; en = 1'b1;
        expect_pulse(2, b + 1); expect_pulse(2, b + 2);
        for (int i = 1; i <= 4; i++) expect_pulse(0, b + 2 * i);
        snap(b + 1, 1, 0, 0); snap(b + 2, 0, 1, 0); snap(b + 3, 1, 0, 0);
        load(0);
        load(1);
        wait_until(b + 8);
        do_reset();

        // 5: N=6, freeze at cnt=3, then load while frozen
        b = cyc; en = 1'b1;
        expect_pulse(1, b + 2); expect_pulse(1, b + 16);
        expect_pulse(0, b + 2); expect_pulse(0, b + 12); expect_pulse(0, b + 20); expect_pulse(0, b + 24);
        snap(b + 6, 3, 0, 0); snap(b + 9, 3, 0, 0); snap(b + 10, 4, 0, 0); snap(b + 12, 0, 1, 0);
        snap(b + 15, 2, 1, 1); snap(b + 16, 0, -1, 0); snap(b + 17, 1, -1, 0);
        load(6);
        wait_until(b + 5);
        en = 1'b0;
        wait_until(b + 9);
        en = 1'b1;
        wait_until(b + 14);
        en = 1'b0;
        load(4);
        wait_until(b + 16);
        en = 1'b1;
        wait_until(b + 24);
        do_reset();

        // 6: N=15 pulse mode, then back-to-back loads 4 and 9
        b = cyc; en = 1'b1; mode = 1'b1;
        expect_pulse(1, b + 2); expect_pulse(1, b + 32);
        expect_pulse(0, b + 2); expect_pulse(0, b + 17); expect_pulse(0, b + 32);
        expect_pulse(0, b + 41); expect_pulse(0, b + 50);
        snap(b + 1, 1, 0, 1); snap(b + 2, 0, 1, 0); snap(b + 16, 14, 0, 0); snap(b + 17, 0, 1, 0);
        snap(b + 18, 1, 0, 0); snap(b + 19, 2, 0, 1); snap(b + 20, 3, 0, 1); snap(b + 31, 14, 0, 1);
        snap(b + 32, 0, 1, 0); snap(b + 33, 1, 0, 0); snap(b + 40, 8, 0, 0); snap(b + 41, 0, 1, 0);
        load(15);
        wait_until(b + 18);
        load(4);
        load(9);
        wait_until(b + 52);
        @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            while (pq[k].size() > 0) begin
                checks++; errors++;
                $display("FAIL %s leftover: got none, expected pulse at edge %0d", pname[k], pq[k][0]);
                void'(pq[k].pop_front());
            end
        end
        while (sq.size() > 0) begin
            checks++; errors++;
            $display("FAIL snapshot leftover: got none, expected check at edge %0d", sq[0].e);
            void'(sq.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
